// File: rtl/vga_sync_gen_if.sv
// Bundle of pixel coordinates, frame pacing and pin-level sync signals
// produced by vga_sync_gen for the drawing stages and the VGA DAC.
interface vga_sync_gen_if;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        displayEn;
  logic        startOfFrame;
  logic [7:0]  frameCount;
  logic        vgaHSyncN;
  logic        vgaVSyncN;
  logic        vgaBlankN;

  modport master (
    output pixelX, pixelY, displayEn, startOfFrame, frameCount,
           vgaHSyncN, vgaVSyncN, vgaBlankN
  );

  modport slave (
    input  pixelX, pixelY, displayEn, startOfFrame, frameCount,
           vgaHSyncN, vgaVSyncN, vgaBlankN
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA pixel-timing generator: horizontal/vertical counters, frame pacing and
// sync/blank pins delayed to line up with the registered RGB of the drawers.
module vga_sync_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 1   // legal range 1..4
) (
  input  logic            clk,
  input  logic            resetN,
  vga_sync_gen_if.master  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
  localparam logic [10:0] HS_FIRST   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_LAST    = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_LAST    = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic blank_n;
  } pins_t;

  localparam pins_t PINS_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, blank_n: 1'b0};

  logic [10:0] h_count;
  logic [10:0] v_count;
  logic [7:0]  frame_count;
  logic        h_wrap;
  logic        v_wrap;
  logic        display_en;
  pins_t       pins_now;
  pins_t       chain [PIPE_DELAY];

  assign h_wrap = (h_count == H_LAST);
  assign v_wrap = (v_count == V_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      h_count     <= '0;
      v_count     <= '0;
      frame_count <= '0;
    end else begin
      h_count <= h_wrap ? 11'd0 : h_count + 11'd1;
      if (h_wrap) begin
        v_count <= v_wrap ? 11'd0 : v_count + 11'd1;
        if (v_wrap) begin
          frame_count <= frame_count + 8'd1;
        end
      end
    end
  end

  always_comb begin
    display_en       = (h_count < H_VIS) && (v_count < V_VIS);
    pins_now.hsync_n = !((h_count >= HS_FIRST) && (h_count <= HS_LAST));
    pins_now.vsync_n = !((v_count >= VS_FIRST) && (v_count <= VS_LAST));
    pins_now.blank_n = display_en;
  end

  // NOTE: every stage of the delay chain is reset, so a reset mid-pulse can
  // never let a stale sync level drain out to the pins afterwards.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        chain[i] <= PINS_IDLE;
      end
    end else begin
      chain[0] <= pins_now;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign vga.pixelX       = h_count;
  assign vga.pixelY       = v_count;
  assign vga.displayEn    = display_en;
  assign vga.startOfFrame = (h_count == 11'd0) && (v_count == 11'd0);
  assign vga.frameCount   = frame_count;
  assign vga.vgaHSyncN    = chain[PIPE_DELAY-1].hsync_n;
  assign vga.vgaVSyncN    = chain[PIPE_DELAY-1].vsync_n;
  assign vga.vgaBlankN    = chain[PIPE_DELAY-1].blank_n;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: full-size builds with PIPE_DELAY 1 and 3
// for line timing, and a shrunken build for frame pacing and reset corners.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_main = 1'b0;
  logic rst_small = 1'b0;

  always #5 clk = ~clk;

  vga_sync_gen_if vif_p1 ();
  vga_sync_gen_if vif_p3 ();
  vga_sync_gen_if vif_s  ();

  vga_sync_gen #(.PIPE_DELAY(1)) dut_p1 (
    .clk   (clk),
    .resetN(rst_main),
    .vga   (vif_p1)
  );

  vga_sync_gen #(.PIPE_DELAY(3)) dut_p3 (
    .clk   (clk),
    .resetN(rst_main),
    .vga   (vif_p3)
  );

  // Small frame: H 8+2+4+2 = 16 clocks, V 4+1+1+1 = 7 lines, 112 clocks/frame.
  // hsync low at hCount 10..13, vsync low on line 5.
  vga_sync_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .PIPE_DELAY(1)
  ) dut_s (
    .clk   (clk),
    .resetN(rst_small),
    .vga   (vif_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [10:0] x;
    logic [10:0] y;
    logic        de;
    logic        sof;
    logic        hs1;
    logic        vs;
    logic        bl1;
    logic        hs3;
    logic        bl3;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  initial begin
    int n;
    int cnt_bl1, cnt_hs1, cnt_bl3, cnt_hs3;
    int first_vs, vs_low, sof1, sof2, fc1, fc2;
    bit found;

    // cyc = posedges since reset release; 0 is sampled with reset held.
    // Pins at PIPE_DELAY=d reflect the decode of count cyc-d (idle before).
    //          cyc   x     y  de sof hs1 vs bl1 hs3 bl3
    vecs[0]  = '{0,   0,    0, 1, 1,  1,  1, 0,  1,  0};
    vecs[1]  = '{1,   1,    0, 1, 0,  1,  1, 1,  1,  0};
    vecs[2]  = '{639, 639,  0, 1, 0,  1,  1, 1,  1,  1};
    vecs[3]  = '{640, 640,  0, 0, 0,  1,  1, 1,  1,  1};
    vecs[4]  = '{641, 641,  0, 0, 0,  1,  1, 0,  1,  1};
    vecs[5]  = '{642, 642,  0, 0, 0,  1,  1, 0,  1,  1};
    vecs[6]  = '{643, 643,  0, 0, 0,  1,  1, 0,  1,  0};
    vecs[7]  = '{656, 656,  0, 0, 0,  1,  1, 0,  1,  0};
    vecs[8]  = '{657, 657,  0, 0, 0,  0,  1, 0,  1,  0};
    vecs[9]  = '{658, 658,  0, 0, 0,  0,  1, 0,  1,  0};
    vecs[10] = '{659, 659,  0, 0, 0,  0,  1, 0,  0,  0};
    vecs[11] = '{752, 752,  0, 0, 0,  0,  1, 0,  0,  0};
    vecs[12] = '{753, 753,  0, 0, 0,  1,  1, 0,  0,  0};
    vecs[13] = '{754, 754,  0, 0, 0,  1,  1, 0,  0,  0};
    vecs[14] = '{755, 755,  0, 0, 0,  1,  1, 0,  1,  0};
    vecs[15] = '{799, 799,  0, 0, 0,  1,  1, 0,  1,  0};
    vecs[16] = '{800, 0,    1, 1, 0,  1,  1, 0,  1,  0};
    vecs[17] = '{801, 1,    1, 1, 0,  1,  1, 1,  1,  0};
    vecs[18] = '{803, 3,    1, 1, 0,  1,  1, 1,  1,  1};

    // Reset held 10 clocks; vector 0 is sampled while it is still asserted.
    repeat (10) @(negedge clk);
    n = 0;
    for (int i = 0; i < NVEC; i++) begin
      while (n < vecs[i].cyc) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("pixelX@%0d", n),    vif_p1.pixelX,       vecs[i].x);
      check($sformatf("pixelY@%0d", n),    vif_p1.pixelY,       vecs[i].y);
      check($sformatf("displayEn@%0d", n), vif_p1.displayEn,    vecs[i].de);
      check($sformatf("sof@%0d", n),       vif_p1.startOfFrame, vecs[i].sof);
      check($sformatf("hsync_p1@%0d", n),  vif_p1.vgaHSyncN,    vecs[i].hs1);
      check($sformatf("vsync_p1@%0d", n),  vif_p1.vgaVSyncN,    vecs[i].vs);
      check($sformatf("blank_p1@%0d", n),  vif_p1.vgaBlankN,    vecs[i].bl1);
      check($sformatf("hsync_p3@%0d", n),  vif_p3.vgaHSyncN,    vecs[i].hs3);
      check($sformatf("vsync_p3@%0d", n),  vif_p3.vgaVSyncN,    vecs[i].vs);
      check($sformatf("blank_p3@%0d", n),  vif_p3.vgaBlankN,    vecs[i].bl3);
      if (n == 0) begin
        check("frameCount_reset", vif_p1.frameCount, 0);
        rst_main = 1'b1;
      end
    end

    // One full line period of pin activity on a visible line.
    cnt_bl1 = 0; cnt_hs1 = 0; cnt_bl3 = 0; cnt_hs3 = 0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if (vif_p1.vgaBlankN)  cnt_bl1++;
      if (!vif_p1.vgaHSyncN) cnt_hs1++;
      if (vif_p3.vgaBlankN)  cnt_bl3++;
      if (!vif_p3.vgaHSyncN) cnt_hs3++;
    end
    check("blank_high_clocks_p1", cnt_bl1, 640);
    check("hsync_low_clocks_p1",  cnt_hs1, 96);
    check("blank_high_clocks_p3", cnt_bl3, 640);
    check("hsync_low_clocks_p3",  cnt_hs3, 96);

    // Small build: two frames of startOfFrame/frameCount/vsync timing.
    check("small_reset_pixelX", vif_s.pixelX, 0);
    check("small_reset_vsync",  vif_s.vgaVSyncN, 1);
    rst_small = 1'b1;
    first_vs = -1; vs_low = 0; sof1 = -1; sof2 = -1; fc1 = -1; fc2 = -1;
    for (int k = 1; k <= 224; k++) begin
      @(negedge clk);
      if (!vif_s.vgaVSyncN) begin
        if (first_vs < 0) first_vs = k;
        if (k <= 112) vs_low++;
      end
      if (vif_s.startOfFrame) begin
        if (sof1 < 0) begin
          sof1 = k; fc1 = int'(vif_s.frameCount);
        end else if (sof2 < 0) begin
          sof2 = k; fc2 = int'(vif_s.frameCount);
        end
      end
    end
    check("vsync_first_low", first_vs, 81);
    check("vsync_low_clocks", vs_low, 16);
    check("sof_first", sof1, 112);
    check("frameCount_first", fc1, 1);
    check("sof_second", sof2, 224);
    check("frameCount_second", fc2, 2);

    // Run on to frame 255, then watch the 255 -> 0 wrap.
    found = 1'b0;
    for (int k = 0; k < 30000 && !found; k++) begin
      @(negedge clk);
      if (vif_s.startOfFrame && vif_s.frameCount == 8'd255) found = 1'b1;
    end
    check("reach_frame_255", found, 1);
    repeat (111) @(negedge clk);
    check("pre_wrap_sof", vif_s.startOfFrame, 0);
    check("pre_wrap_frameCount", vif_s.frameCount, 255);
    @(negedge clk);
    check("wrap_sof", vif_s.startOfFrame, 1);
    check("wrap_frameCount", vif_s.frameCount, 0);

    // Reset asserted inside both sync pulses.
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (vif_s.pixelX == 11'd12 && vif_s.pixelY == 11'd5) found = 1'b1;
    end
    check("reach_12_5", found, 1);
    check("mid_hsync_active", vif_s.vgaHSyncN, 0);
    check("mid_vsync_active", vif_s.vgaVSyncN, 0);
    rst_small = 1'b0;
    #1;
    check("mid_reset_hsync", vif_s.vgaHSyncN, 1);
    check("mid_reset_vsync", vif_s.vgaVSyncN, 1);
    check("mid_reset_pixelX", vif_s.pixelX, 0);
    check("mid_reset_pixelY", vif_s.pixelY, 0);
    repeat (3) @(negedge clk);
    rst_small = 1'b1;
    n = -1;
    for (int k = 1; k <= 100 && n < 0; k++) begin
      @(negedge clk);
      if (!vif_s.vgaHSyncN) n = k;
    end
    check("hsync_fall_after_release", n, 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
